// File: rtl/half_argmax_v.sv
// Sequential argmax over a vector of IEEE-754 binary16 values, one element per cycle.
// Lowest index wins ties, and a NaN never displaces a non-NaN best.
module half_argmax_v #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      vector_a [WIDTH],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] max_index,
  output logic [15:0]      max_value
);

  localparam bit               MULTI    = (WIDTH > 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [15:0]      vec_q [WIDTH];
  logic [15:0]      best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] idx;
  logic [15:0]      cur;
  logic             take;
  logic             last;

  // Monotonic unsigned key: negatives are bit-inverted, non-negatives get the sign flipped.
  function automatic logic [15:0] order_key(input logic [15:0] x);
    return x[15] ? ~x : (x ^ 16'h8000);
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  assign cur  = vec_q[idx];
  assign last = (idx == LAST_IDX);
  assign take = !is_nan(cur) && (is_nan(best) || (order_key(cur) > order_key(best)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MULTI ? SCAN : DONE;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture on accept, then fold one element per SCAN cycle into the running best.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(WIDTH); i++) vec_q[i] <= '0;
      best      <= '0;
      best_idx  <= '0;
      idx       <= '0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < int'(WIDTH); i++) vec_q[i] <= vector_a[i];
            best     <= vector_a[0];
            best_idx <= '0;
            idx      <= MULTI ? IDX_W'(1) : '0;
            if (!MULTI) begin
              max_index <= '0;
              max_value <= vector_a[0];
            end
          end
        end
        SCAN: begin
          if (take) begin
            best     <= cur;
            best_idx <= idx;
          end
          if (last) begin
            max_index <= take ? idx : best_idx;
            max_value <= take ? cur : best;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_half_argmax_v.sv
// Scoreboard bench for half_argmax_v with three instances (WIDTH 10, 4 and 1).
module tb_half_argmax_v;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv10, ir10, ov10, or10;
  logic [15:0] va10 [10];
  logic [3:0]  mi10;
  logic [15:0] mv10;
  logic        iv4, ir4, ov4, or4;
  logic [15:0] va4 [4];
  logic [1:0]  mi4;
  logic [15:0] mv4;
  logic        iv1, ir1, ov1, or1;
  logic [15:0] va1 [1];
  logic [0:0]  mi1;
  logic [15:0] mv1;

  half_argmax_v #(.WIDTH(10)) u_dut10 (.clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10),
    .vector_a(va10), .out_valid(ov10), .out_ready(or10), .max_index(mi10), .max_value(mv10));
  half_argmax_v #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .vector_a(va4), .out_valid(ov4), .out_ready(or4), .max_index(mi4), .max_value(mv4));
  half_argmax_v #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .vector_a(va1), .out_valid(ov1), .out_ready(or1), .max_index(mi1), .max_value(mv1));

  typedef logic [15:0] vec_t [10];
  typedef struct { int idx; logic [15:0] val; } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur     = 10;

  function automatic bit h_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 0);
  endfunction

  // Numeric value of a half; infinities map beyond the largest finite half.
  function automatic real h2r(input logic [15:0] x);
    real mag;
    int  e;
    e = int'(x[14:10]);
    if (e == 0)       mag = real'(x[9:0]) / 16777216.0;
    else if (e == 31) mag = 1.0e9;
    else              mag = real'(1024 + int'(x[9:0])) * (2.0 ** (e - 25));
    return x[15] ? -mag : mag;
  endfunction

  function automatic bit h_gt(input logic [15:0] a, input logic [15:0] b);
    real ra, rb;
    ra = h2r(a);
    rb = h2r(b);
    if (ra > rb) return 1'b1;
    return (ra == rb) && (ra == 0.0) && !a[15] && b[15];
  endfunction

  function automatic exp_t model(input vec_t v, input int n);
    exp_t r;
    int   b;
    b = 0;
    for (int i = 1; i < n; i++)
      if (!h_nan(v[i]) && (h_nan(v[b]) || h_gt(v[i], v[b]))) b = i;
    r.idx = b;
    r.val = v[b];
    return r;
  endfunction

  function automatic logic get_ir();
    case (cur) 10: return ir10; 4: return ir4; default: return ir1; endcase
  endfunction
  function automatic logic get_ov();
    case (cur) 10: return ov10; 4: return ov4; default: return ov1; endcase
  endfunction
  function automatic int get_mi();
    case (cur) 10: return int'(mi10); 4: return int'(mi4); default: return int'(mi1); endcase
  endfunction
  function automatic logic [15:0] get_mv();
    case (cur) 10: return mv10; 4: return mv4; default: return mv1; endcase
  endfunction

  task automatic drive_in(input logic iv, input vec_t v);
    case (cur)
      10: begin iv10 = iv; for (int i = 0; i < 10; i++) va10[i] = v[i]; end
      4:  begin iv4 = iv; for (int i = 0; i < 4; i++) va4[i] = v[i]; end
      default: begin iv1 = iv; va1[0] = v[0]; end
    endcase
  endtask

  task automatic set_or(input logic r);
    case (cur) 10: or10 = r; 4: or4 = r; default: or1 = r; endcase
  endtask

  task automatic rand_vec(output vec_t v);
    for (int i = 0; i < 10; i++) v[i] = 16'($urandom_range(0, 65535));
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_vec(input int w, input vec_t v, input int exp_idx, input logic [15:0] exp_val,
                         input int hold, input string name);
    exp_t e;
    exp_t got;
    vec_t junk;
    cur = w;
    if (exp_idx < 0) e = model(v, w);
    else begin e.idx = exp_idx; e.val = exp_val; end
    sb.push_back(e);
    n_tests++;
    if (get_ir() !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: in_ready=%b required 1", name, get_ir());
    end
    drive_in(1'b1, v);
    set_or(1'b0);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      rand_vec(junk);
      drive_in(1'b0, junk);
      n_tests++;
      if (get_ov() !== (k == w) || get_ir() !== 1'b0) begin
        n_fail++;
        $display("FAIL %s latency T+%0d: out_valid=%b in_ready=%b required %b/0",
                 name, k, get_ov(), get_ir(), (k == w));
      end
    end
    got = sb.pop_front();
    n_tests++;
    if (get_mi() !== got.idx || get_mv() !== got.val) begin
      n_fail++;
      $display("FAIL %s result: idx=%0d val=%h required idx=%0d val=%h",
               name, get_mi(), get_mv(), got.idx, got.val);
    end
    for (int h = 0; h < hold; h++) begin
      rand_vec(junk);
      drive_in(1'b1, junk);
      @(negedge clk);
      n_tests++;
      if (get_ov() !== 1'b1 || get_ir() !== 1'b0 || get_mi() !== got.idx || get_mv() !== got.val) begin
        n_fail++;
        $display("FAIL %s hold %0d: ov=%b ir=%b idx=%0d val=%h required 1/0/%0d/%h",
                 name, h, get_ov(), get_ir(), get_mi(), get_mv(), got.idx, got.val);
      end
    end
    drive_in(1'b0, junk);
    set_or(1'b1);
    @(negedge clk);
    set_or(1'b0);
    n_tests++;
    if (get_ir() !== 1'b1 || get_ov() !== 1'b0 || get_mi() !== got.idx || get_mv() !== got.val) begin
      n_fail++;
      $display("FAIL %s release: ir=%b ov=%b idx=%0d val=%h required 1/0/%0d/%h",
               name, get_ir(), get_ov(), get_mi(), get_mv(), got.idx, got.val);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ov10 !== 1'b0 || mi10 !== 4'd0 || mv10 !== 16'h0000 || ov4 !== 1'b0 || mi4 !== 2'd0
        || mv4 !== 16'h0000 || ov1 !== 1'b0 || mv1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs: ov=%b%b%b mv=%h/%h/%h required zeros", ov10, ov4, ov1, mv10, mv4, mv1);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ir10 !== 1'b1 || ir4 !== 1'b1 || ir1 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b%b%b required 111", ir10, ir4, ir1);
    end
  endtask

  task automatic test_basic();
    vec_t v;
    v = '{16'h3400, 16'h3800, 16'h3A00, 16'h3C00, 16'h3800, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3400};
    run_vec(10, v, 3, 16'h3C00, 0, "basic10");
    v = '{16'h3400, 16'h3400, 16'h3A00, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3A00, 16'h3400, 16'h3400};
    run_vec(10, v, 2, 16'h3A00, 0, "tie10");
  endtask

  task automatic test_signs_nan();
    vec_t v;
    v = '{16'hBC00, 16'hC000, 16'h8000, 16'h0000, 0, 0, 0, 0, 0, 0};
    run_vec(4, v, 3, 16'h0000, 0, "zero_sign");
    v = '{16'hC000, 16'hBC00, 16'hC000, 16'hC000, 0, 0, 0, 0, 0, 0};
    run_vec(4, v, 1, 16'hBC00, 0, "negatives");
    v = '{16'h7E00, 16'h3400, 16'h7E00, 16'h3800, 0, 0, 0, 0, 0, 0};
    run_vec(4, v, 3, 16'h3800, 0, "nan_first");
    v = '{16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00, 0, 0, 0, 0, 0, 0};
    run_vec(4, v, 0, 16'h7E00, 0, "all_nan");
    v = '{16'hFC00, 16'h7BFF, 16'h7C00, 16'h7C00, 0, 0, 0, 0, 0, 0};
    run_vec(4, v, 2, 16'h7C00, 0, "infinity");
  endtask

  task automatic test_backpressure();
    vec_t v;
    v = '{16'h3400, 16'h4000, 16'h3800, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h4200, 16'h3400, 16'h3400};
    run_vec(10, v, 7, 16'h4200, 5, "backpressure");
  endtask

  task automatic test_rst_mid_scan();
    vec_t v;
    v = '{16'h3400, 16'h4400, 16'h3800, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3400};
    cur = 10;
    drive_in(1'b1, v);
    set_or(1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive_in(1'b0, v);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (ov10 !== 1'b0 || mi10 !== 4'd0 || mv10 !== 16'h0000 || ir10 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_scan: ov=%b idx=%0d val=%h ir=%b required 0/0/0000/1", ov10, mi10, mv10, ir10);
    end
    v = '{16'h3400, 16'h3800, 16'hC000, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3400, 16'h3C00};
    run_vec(10, v, 9, 16'h3C00, 0, "post_reset");
  endtask

  task automatic test_width1();
    vec_t v;
    v = '{16'hC400, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_vec(1, v, 0, 16'hC400, 0, "width1");
    v = '{16'h7E00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_vec(1, v, 0, 16'h7E00, 2, "width1_nan");
  endtask

  task automatic test_back_to_back();
    vec_t v;
    for (int r = 0; r < 12; r++) begin
      rand_vec(v);
      if (r % 3 == 0) v[$urandom_range(0, 9)] = 16'h7E01;
      run_vec((r % 2 == 0) ? 10 : 4, v, -1, 16'h0, r % 3, "random");
    end
  endtask

  initial begin
    vec_t z;
    for (int i = 0; i < 10; i++) z[i] = '0;
    rst = 1'b1;
    cur = 10; drive_in(1'b0, z); set_or(1'b0);
    cur = 4;  drive_in(1'b0, z); set_or(1'b0);
    cur = 1;  drive_in(1'b0, z); set_or(1'b0);
    @(negedge clk);
    test_reset();
    test_basic();
    test_signs_nan();
    test_backpressure();
    test_rst_mid_scan();
    test_width1();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/half_argmax_v.md
HALF_ARGMAX_V -- requirements
Module: half_argmax_v

Interface
REQ-001 SHALL have parameter WIDTH, default 10: number of half-precision elements per input vector, legal range 1..256.
REQ-002 SHALL have parameter IDX_W, default $clog2(WIDTH) with a minimum of 1: width of the index output.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  vector_a holds a valid vector (typically driven by the sigmoid vector stage out_valid).
REQ-006 SHALL have port in_ready  output  1  block can accept a vector this cycle.
REQ-007 SHALL have port vector_a  input  16 x WIDTH (unpacked array [WIDTH])  IEEE-754 binary16 elements.
REQ-008 SHALL have port out_valid  output  1  max_index and max_value are valid.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-010 SHALL have port max_index  output  IDX_W  index of the largest element.
REQ-011 SHALL have port max_value  output  16  binary16 value of the largest element.

Function
REQ-012 SHALL implement the states IDLE, SCAN and DONE.
REQ-013 IDLE SHALL drive in_ready=1 and out_valid=0; in every other state in_ready SHALL be 0.
REQ-014 When in_valid=1 and in_ready=1 in cycle T, the block SHALL register all WIDTH elements, set best=element 0 and best_idx=0, then enter SCAN if WIDTH>1, or DONE if WIDTH=1.
REQ-015 SCAN SHALL compare exactly one element per cycle, elements 1..WIDTH-1 in ascending order.
REQ-016 In SCAN, best and best_idx SHALL update only when the current element is strictly greater than best; ties therefore keep the lowest index.
REQ-017 After comparing element WIDTH-1, SCAN SHALL enter DONE.
REQ-018 out_valid SHALL first assert in cycle T+WIDTH, where T is the accept cycle.
REQ-019 DONE SHALL hold out_valid=1 with max_index and max_value stable until out_ready=1, then return to IDLE on the next edge.
REQ-020 in_valid SHALL be ignored outside IDLE; vector_a SHALL be sampled only in the accept cycle.
REQ-021 Ordering SHALL use the key {~x[15:0]} for negative x (sign=1) and {x ^ 16'h8000} otherwise, compared as unsigned.
REQ-022 Under that ordering, -0 SHALL rank below +0 and infinities SHALL rank at their signed extremes.
REQ-023 A NaN element (exponent 5'h1F, mantissa != 0) SHALL never replace best.
REQ-024 If element 0 is NaN, the first non-NaN element SHALL replace it.
REQ-025 If all elements are NaN, the outputs SHALL be max_index=0 and max_value=element 0.
REQ-026 max_index and max_value SHALL hold their last values outside DONE; they are qualified only by out_valid.
REQ-027 The index counter SHALL be IDX_W wide and SHALL NOT wrap past WIDTH-1.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, out_valid=0, max_index=0, max_value=16'h0000 and all internal registers to 0.
REQ-029 rst SHALL take priority over any in_valid or out_ready in the same cycle.
REQ-030 rst asserted during SCAN or DONE SHALL abandon the vector without producing out_valid.
REQ-031 in_ready SHALL be 1 in the first cycle after rst is released.

Verification
REQ-032 WIDTH=10, vector {3400,3800,3A00,3C00,3800,3400,3400,3400,3400,3400}, out_ready=1 -> out_valid at T+10, max_index=3, max_value=16'h3C00, in_ready=1 at T+11.
REQ-033 WIDTH=10, tie {3A00 at idx 2 and idx 7, all others 3400} -> max_index=2, max_value=16'h3A00.
REQ-034 WIDTH=4, {BC00,C000,8000,0000} -> max_index=3 (+0 above -0); then {C000,BC00,C000,C000} -> max_index=1, max_value=16'hBC00.
REQ-035 WIDTH=4, {7E00,3400,7E00,3800} -> max_index=3, max_value=16'h3800; all-NaN {7E00 x4} -> max_index=0, max_value=16'h7E00.
REQ-036 Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst pulse during SCAN at T+4 -> out_valid never asserts and outputs are 0; a new vector is accepted at the first post-reset cycle with correct result; WIDTH=1 -> out_valid at T+1 with max_index=0.
